// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller with registered read port, address range
// checking and an optional zero-fill sweep of the array after reset.
module data_mem_ctrl #(
    parameter int AB         = 11,
    parameter int DB         = 16,
    parameter int DEPTH      = 2 ** AB,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RdRam,
    input  logic          WrRam,
    input  logic [AB-1:0] Addr,
    input  logic [DB-1:0] In_Data,
    output logic [DB-1:0] Out_Data,
    output logic          Rd_Valid,
    output logic          Busy,
    output logic          Addr_Err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [PW-1:0] sweep_ptr_r;
    logic [DB-1:0] mem_r [0:DEPTH-1];

    logic          busy_s;
    logic          sweep_last_s;
    logic          in_range_s;
    logic          acc_wr_s;
    logic          acc_rd_s;
    logic          mem_we_s;
    logic [PW-1:0] mem_waddr_s;
    logic [DB-1:0] mem_wdata_s;
    logic [PW-1:0] addr_idx_s;

    assign sweep_last_s = (sweep_ptr_r == PW'(DEPTH - 1));
    assign in_range_s   = ({1'b0, Addr} < (AB + 1)'(DEPTH));
    assign addr_idx_s   = Addr[PW-1:0];
    assign Busy         = busy_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RST_STATE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: the sweep ends on the edge that clears the last word.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CLEAR:   state_nxt_s = sweep_last_s ? READY : CLEAR;
            READY:   state_nxt_s = READY;
            default: state_nxt_s = RST_STATE;
        endcase
    end

    // Output/decode logic: request acceptance and the single memory write port.
    always_comb begin
        busy_s      = 1'b1;
        acc_wr_s    = 1'b0;
        acc_rd_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = sweep_ptr_r;
        mem_wdata_s = '0;
        case (state_r)
            CLEAR: begin
                busy_s   = 1'b1;
                mem_we_s = rst_n;
            end
            READY: begin
                busy_s   = 1'b0;
                acc_wr_s = WrRam;
                acc_rd_s = RdRam & ~WrRam;
                if (WrRam && in_range_s) begin
                    mem_we_s    = rst_n;
                    mem_waddr_s = addr_idx_s;
                    mem_wdata_s = In_Data;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Sweep pointer advances only while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_ptr_r <= '0;
        end else if (busy_s) begin
            sweep_ptr_r <= sweep_last_s ? '0 : sweep_ptr_r + PW'(1);
        end else begin
            sweep_ptr_r <= sweep_ptr_r;
        end
    end

    // Memory array has no reset; contents are zeroed only by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Registered read data and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out_Data <= '0;
            Rd_Valid <= 1'b0;
            Addr_Err <= 1'b0;
        end else begin
            Rd_Valid <= acc_rd_s;
            Addr_Err <= (acc_rd_s | acc_wr_s) & ~in_range_s;
            if (acc_rd_s) begin
                Out_Data <= in_range_s ? mem_r[addr_idx_s] : '0;
            end else begin
                Out_Data <= Out_Data;
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter AB, default 11, address width in bits.
REQ-002 SHALL have parameter DB, default 16, data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**AB, number of implemented words; legal range 1..2**AB.
REQ-004 SHALL have parameter INIT_CLEAR, default 1, 1 = zero-fill sweep after reset, 0 = no sweep.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-007 SHALL have port RdRam, input, 1, read request for the current cycle.
REQ-008 SHALL have port WrRam, input, 1, write request for the current cycle.
REQ-009 SHALL have port Addr, input, AB, word address.
REQ-010 SHALL have port In_Data, input, DB, write data.
REQ-011 SHALL have port Out_Data, output, DB, registered read data.
REQ-012 SHALL have port Rd_Valid, output, 1, one-cycle pulse marking new Out_Data.
REQ-013 SHALL have port Busy, output, 1, high while the zero-fill sweep runs; requests ignored.
REQ-014 SHALL have port Addr_Err, output, 1, one-cycle pulse for an accepted request with Addr >= DEPTH.

Function
REQ-015 SHALL implement FSM states CLEAR and READY; rst_n low forces CLEAR when INIT_CLEAR=1, READY when INIT_CLEAR=0.
REQ-016 In CLEAR, SHALL write 0 to word sweep_ptr each cycle, sweep_ptr counting 0..DEPTH-1, Busy=1.
REQ-017 SHALL leave CLEAR for READY on the edge that writes word DEPTH-1; Busy falls in that same edge, so the sweep takes exactly DEPTH cycles.
REQ-018 SHALL ignore RdRam/WrRam while Busy=1: no write, Rd_Valid=0, Addr_Err=0.
REQ-019 In READY, with WrRam=1 and Addr<DEPTH, SHALL store In_Data at Addr on the edge.
REQ-020 In READY, with RdRam=1, WrRam=0, Addr<DEPTH, SHALL load Mem[Addr] into Out_Data and pulse Rd_Valid on the edge (latency 1).
REQ-021 WrRam=1 and RdRam=1 together SHALL perform the write only; Rd_Valid=0 that cycle (write priority).
REQ-022 A read of an address written on the previous edge SHALL return the new data.
REQ-023 Out_Data SHALL hold its last value in every cycle without an accepted read.
REQ-024 For an accepted request with Addr>=DEPTH, SHALL discard the write, or for a read SHALL load Out_Data=0 with Rd_Valid=1; Addr_Err=1 for one cycle in both cases.
REQ-025 Rd_Valid and Addr_Err SHALL be 0 in any cycle without an accepted request.

Reset
REQ-026 On rst_n low, SHALL immediately set Out_Data=0, Rd_Valid=0, Addr_Err=0, sweep_ptr=0, Busy=INIT_CLEAR.
REQ-027 Reset SHALL NOT clear memory directly; contents are zeroed only by the sweep.
REQ-028 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.
REQ-029 Reset asserted while a request is presented SHALL cancel it; no write, no Rd_Valid.

Verification
REQ-030 AB=4, DEPTH=16, INIT_CLEAR=1, pre-load random garbage, release rst_n -> Busy high exactly 16 cycles; then reading 0..15 gives 0 with Rd_Valid each.
REQ-031 Write 0x3FC0 to Addr 4, read Addr 4 on the next cycle -> Out_Data=0x3FC0 one edge later, Rd_Valid one-cycle pulse.
REQ-032 WrRam=RdRam=1, Addr 2, In_Data 0xA5A5 -> Rd_Valid=0, Out_Data unchanged; a following read of Addr 2 returns 0xA5A5.
REQ-033 DEPTH=10, write 0x1234 to Addr 12, then read Addr 12 -> both cycles pulse Addr_Err; read gives Out_Data=0, Rd_Valid=1; Mem[2] unchanged.
REQ-034 Assert rst_n low at sweep cycle 7, release -> Out_Data=0 immediately, Busy stays high for a fresh 16 cycles, all words read back 0.
REQ-035 Requests during Busy (write 0xFFFF to Addr 3) -> ignored; after the sweep, Addr 3 reads 0.
